// File: rtl/pipe_fwd_chain.sv
// Post-decode pipeline register chain (destination tag, write-enable, result) with a
// youngest-first operand bypass network, per-stage flush, late result update and stall detect.
module pipe_fwd_chain #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NRD   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold_i,
  input  logic [DEPTH-1:0]       flush_i,
  input  logic                   in_valid_i,
  input  logic                   in_we_i,
  input  logic [AW-1:0]          in_rd_i,
  input  logic [WIDTH-1:0]       in_data_i,
  input  logic                   in_dok_i,
  input  logic [DEPTH-1:0]       upd_valid_i,
  input  logic [DEPTH*WIDTH-1:0] upd_data_i,
  input  logic [NRD*AW-1:0]      rs_i,
  output logic [NRD-1:0]         fwd_hit_o,
  output logic [NRD*WIDTH-1:0]   fwd_data_o,
  output logic [NRD-1:0]         fwd_stall_o,
  output logic                   wb_we_o,
  output logic [AW-1:0]          wb_rd_o,
  output logic [WIDTH-1:0]       wb_data_o,
  output logic [31:0]            retired_o
);

  logic [DEPTH-1:0] stg_v, stg_we, stg_dok;
  logic [AW-1:0]    stg_rd   [DEPTH];
  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [31:0]      retired_q;

  logic [DEPTH-1:0] src_v, src_we, src_dok;
  logic [AW-1:0]    src_rd   [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];

  // Entry each stage would take on an advance; a result arriving for stage k-1 rides along.
  always_comb begin
    src_v[0]    = in_valid_i;
    src_we[0]   = in_we_i;
    src_rd[0]   = in_rd_i;
    src_data[0] = in_data_i;
    src_dok[0]  = in_dok_i;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k]    = stg_v[k-1];
      src_we[k]   = stg_we[k-1];
      src_rd[k]   = stg_rd[k-1];
      src_data[k] = upd_valid_i[k-1] ? upd_data_i[(k-1)*WIDTH +: WIDTH] : stg_data[k-1];
      src_dok[k]  = stg_dok[k-1] | upd_valid_i[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_v     <= '0;
      stg_we    <= '0;
      stg_dok   <= '0;
      retired_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stg_rd[k]   <= '0;
        stg_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush_i[k]) begin
          stg_v[k]   <= 1'b0;
          stg_we[k]  <= 1'b0;
          stg_dok[k] <= 1'b0;
        end else if (hold_i) begin
          if (upd_valid_i[k]) begin
            stg_data[k] <= upd_data_i[k*WIDTH +: WIDTH];
            stg_dok[k]  <= 1'b1;
          end
        end else begin
          stg_v[k]    <= src_v[k];
          stg_we[k]   <= src_we[k];
          stg_rd[k]   <= src_rd[k];
          stg_data[k] <= src_data[k];
          stg_dok[k]  <= src_dok[k];
        end
      end
      if (!hold_i && stg_v[DEPTH-1] && !flush_i[DEPTH-1])
        retired_q <= retired_q + 32'd1;
    end
  end

  // Lookup: youngest matching producer wins, even when its result is still pending.
  always_comb begin
    logic          found;
    logic [AW-1:0] rs_p;
    fwd_hit_o   = '0;
    fwd_stall_o = '0;
    fwd_data_o  = '0;
    for (int p = 0; p < NRD; p++) begin
      found = 1'b0;
      rs_p  = rs_i[p*AW +: AW];
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && stg_v[k] && stg_we[k] && stg_rd[k] == rs_p && rs_p != '0) begin
          found = 1'b1;
          if (stg_dok[k]) begin
            fwd_hit_o[p]                = 1'b1;
            fwd_data_o[p*WIDTH +: WIDTH] = stg_data[k];
          end else begin
            fwd_stall_o[p] = 1'b1;
          end
        end
      end
    end
  end

  assign wb_we_o   = stg_v[DEPTH-1] & stg_we[DEPTH-1] & (stg_rd[DEPTH-1] != '0) & stg_dok[DEPTH-1];
  assign wb_rd_o   = stg_rd[DEPTH-1];
  assign wb_data_o = stg_data[DEPTH-1];
  assign retired_o = retired_q;

  // A writing instruction must have its result by the time it reaches writeback.
  wb_result_known: assert property (@(posedge clk) disable iff (!rst_n)
    !(stg_v[DEPTH-1] && stg_we[DEPTH-1] && stg_rd[DEPTH-1] != '0 && !stg_dok[DEPTH-1]));

endmodule
